// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FPU core between NUM_REQ requesters.
// Enforces a DIV issue interval and routes each result back to its issuer via a tag pipeline.
module fpu_issue_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned DIV_II  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*69-1:0]  req_instr,
    output logic [68:0]            fpu_i,
    output logic                   fpu_start,
    input  logic [31:0]            fpu_out,
    input  logic [7:0]             fpu_flags,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_out,
    output logic [7:0]             resp_flags,
    output logic                   busy
);

    localparam int unsigned InstrW = 69;
    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW   = $clog2(DIV_II) + 1;
    localparam logic [2:0]  OpDiv  = 3'd3;
    localparam logic [31:0] QNaN   = 32'h7FC0_0000;

    typedef enum logic [0:0] {StReady, StDivHold} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     grant_idx;
    logic [IdxW-1:0]     cand;
    logic                grant_found;
    logic [InstrW-1:0]   sel_instr;
    logic                sel_illegal;
    logic                sel_div;
    logic [InstrW-1:0]   fpu_i_q;
    logic [FPU_LAT:0]    tag_valid_q;
    logic [FPU_LAT:0]    tag_ill_q;
    logic [IdxW-1:0]     tag_idx_q [FPU_LAT+1];
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]         resp_out_q, resp_out_d;
    logic [7:0]          resp_flags_q, resp_flags_d;

    // Grant search starts at rr_ptr and wraps; gated by reset so outputs read 0 during reset.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready   = '0;
        if (state_q == StReady && !reset) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_instr   = req_instr[32'(grant_idx)*InstrW +: InstrW];
    assign sel_illegal = sel_instr[68];
    assign sel_div     = (sel_instr[68:66] == OpDiv);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReady: begin
                if (grant_found && sel_div && DIV_II > 1) begin
                    state_d = StDivHold;
                    cnt_d   = CntW'(DIV_II - 1);
                end
            end
            StDivHold: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // Illegal ops travel the tag pipeline like real ops but get a forced qNaN response.
    always_comb begin
        resp_valid_d = '0;
        resp_out_d   = '0;
        resp_flags_d = '0;
        if (tag_valid_q[FPU_LAT]) begin
            resp_valid_d[tag_idx_q[FPU_LAT]] = 1'b1;
            if (tag_ill_q[FPU_LAT]) begin
                resp_out_d   = QNaN;
                resp_flags_d = 8'h20;
            end else begin
                resp_out_d   = fpu_out;
                resp_flags_d = fpu_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StReady;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            fpu_i_q      <= '0;
            tag_valid_q  <= '0;
            tag_ill_q    <= '0;
            for (int unsigned k = 0; k <= FPU_LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
            resp_valid_q <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            if (grant_found && !sel_illegal) begin
                fpu_i_q <= sel_instr;
            end
            tag_valid_q  <= {tag_valid_q[FPU_LAT-1:0], grant_found};
            tag_ill_q    <= {tag_ill_q[FPU_LAT-1:0], sel_illegal};
            tag_idx_q[0] <= grant_idx;
            for (int unsigned k = 1; k <= FPU_LAT; k++) begin
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign fpu_i      = fpu_i_q;
    assign fpu_start  = tag_valid_q[0] & ~tag_ill_q[0];
    assign resp_valid = resp_valid_q;
    assign resp_out   = resp_out_q;
    assign resp_flags = resp_flags_q;
    assign busy       = (|tag_valid_q) | (state_q == StDivHold) | (|resp_valid_q);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter: vector table for single transactions plus
// hand-written sequences for round-robin, DIV hold and mid-flight reset.
module tb_fpu_issue_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned Lat    = 4;
    localparam int unsigned DivII  = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NumReq-1:0]     req_valid;
    logic [NumReq-1:0]     req_ready;
    logic [NumReq*69-1:0]  req_instr;
    logic [68:0]           fpu_i;
    logic                  fpu_start;
    logic [31:0]           fpu_out;
    logic [7:0]            fpu_flags;
    logic [NumReq-1:0]     resp_valid;
    logic [31:0]           resp_out;
    logic [7:0]            resp_flags;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_issue_arbiter #(
        .NUM_REQ (NumReq),
        .FPU_LAT (Lat),
        .DIV_II  (DivII)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_instr  (req_instr),
        .fpu_i      (fpu_i),
        .fpu_start  (fpu_start),
        .fpu_out    (fpu_out),
        .fpu_flags  (fpu_flags),
        .resp_valid (resp_valid),
        .resp_out   (resp_out),
        .resp_flags (resp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Fixed-latency FPU stand-in: one known ADD result, otherwise opa^opb.
    function automatic logic [31:0] model_res(input logic [68:0] ins);
        if (ins[63:32] == 32'h3F80_0000 && ins[31:0] == 32'h4000_0000) return 32'h4040_0000;
        return ins[63:32] ^ ins[31:0];
    endfunction

    function automatic logic [7:0] model_flags(input logic [68:0] ins);
        if (ins[68:66] == 3'd3 && ins[31:0] == 32'h0) return 8'h81;
        return 8'h00;
    endfunction

    logic [31:0] mdl_out   [Lat];
    logic [7:0]  mdl_flags [Lat];

    always @(posedge clk) begin
        mdl_out[0]   <= fpu_start ? model_res(fpu_i) : 32'hDEAD_BEEF;
        mdl_flags[0] <= fpu_start ? model_flags(fpu_i) : 8'hEE;
        for (int k = 1; k < Lat; k++) begin
            mdl_out[k]   <= mdl_out[k-1];
            mdl_flags[k] <= mdl_flags[k-1];
        end
    end

    assign fpu_out   = mdl_out[Lat-1];
    assign fpu_flags = mdl_flags[Lat-1];

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_instr(input int r, input logic [68:0] ins);
        req_instr[r*69 +: 69] = ins;
    endtask

    typedef struct {
        int          r;
        logic [2:0]  op;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] exp_out;
        logic [7:0]  exp_flags;
        logic        exp_start;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [3:0]  oh;
        logic [31:0] rr_exp [4];
        logic [68:0] ins;

        vecs[0] = '{r: 2, op: 3'd0, opa: 32'h3F80_0000, opb: 32'h4000_0000,
                    exp_out: 32'h4040_0000, exp_flags: 8'h00, exp_start: 1'b1};
        vecs[1] = '{r: 3, op: 3'd6, opa: 32'h1111_1111, opb: 32'h2222_2222,
                    exp_out: 32'h7FC0_0000, exp_flags: 8'h20, exp_start: 1'b0};
        vecs[2] = '{r: 0, op: 3'd3, opa: 32'h4000_0000, opb: 32'h0000_0000,
                    exp_out: 32'h4000_0000, exp_flags: 8'h81, exp_start: 1'b1};
        vecs[3] = '{r: 1, op: 3'd2, opa: 32'h1234_5678, opb: 32'h0F0F_0F0F,
                    exp_out: 32'h1D3B_5977, exp_flags: 8'h00, exp_start: 1'b1};
        vecs[4] = '{r: 1, op: 3'd7, opa: 32'h0000_0001, opb: 32'h0000_0002,
                    exp_out: 32'h7FC0_0000, exp_flags: 8'h20, exp_start: 1'b0};

        reset     = 1'b1;
        req_valid = '0;
        req_instr = '0;

        // Reset state: outputs held at zero even with every requester valid.
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_start", fpu_start, 1'b0);
        check("rst_fpu_i", fpu_i, 69'h0);
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;

        // Single-transaction vectors.
        for (int v = 0; v < 5; v++) begin
            oh  = 4'b0001 << vecs[v].r;
            ins = {vecs[v].op, 2'b00, vecs[v].opa, vecs[v].opb};
            @(negedge clk);
            set_instr(vecs[v].r, ins);
            req_valid = oh;
            #1;
            check("vec_ready", req_ready, oh);
            for (int n = 1; n <= int'(Lat) + 2; n++) begin
                @(negedge clk);
                if (n == 1) req_valid = '0;
                #1;
                if (n == 1) begin
                    check("vec_start", fpu_start, vecs[v].exp_start);
                    if (vecs[v].exp_start) check("vec_fpu_i", fpu_i, ins);
                end
                if (n < int'(Lat) + 2) begin
                    check("vec_resp_early", resp_valid, 4'b0000);
                end else begin
                    check("vec_resp_valid", resp_valid, oh);
                    check("vec_resp_out", resp_out, vecs[v].exp_out);
                    check("vec_resp_flags", resp_flags, vecs[v].exp_flags);
                end
            end
            @(negedge clk);
            #1;
            check("vec_resp_pulse", resp_valid, 4'b0000);
            check("vec_resp_out_idle", resp_out, 32'h0);
            @(negedge clk);
        end

        // Reset with three ADDs in flight.
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_instr(i, {3'd0, 2'b00, 32'(i + 1), 32'h0000_0100});
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        check("mid_busy", busy, 1'b1);
        #1;
        reset     = 1'b1;
        req_valid = '1;
        #1;
        check("mid_rst_ready", req_ready, 4'b0000);
        check("mid_rst_start", fpu_start, 1'b0);
        check("mid_rst_fpu_i", fpu_i, 69'h0);
        check("mid_rst_resp_valid", resp_valid, 4'b0000);
        check("mid_rst_resp_out", resp_out, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        for (int n = 0; n < int'(Lat) + 4; n++) begin
            @(negedge clk);
            #1;
            check("mid_no_resp", resp_valid, 4'b0000);
            check("mid_no_busy", busy, 1'b0);
        end
        req_valid = '1;
        #1;
        check("mid_next_grant", req_ready, 4'b0001);
        req_valid = '0;

        // Round-robin with all requesters valid for 8 cycles.
        for (int i = 0; i < 4; i++) begin
            rr_exp[i] = (32'h1000_0000 * (i + 1)) ^ (32'h11 * (i + 1));
            set_instr(i, {3'd0, 2'b00, 32'h1000_0000 * (i + 1), 32'h11 * (i + 1)});
        end
        for (int c = 0; c < 8 + int'(Lat) + 4; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                oh = 4'b0001 << (c % 4);
                check("rr_grant", req_ready, oh);
            end
            if (c >= int'(Lat) + 2 && c < int'(Lat) + 10) begin
                oh = 4'b0001 << ((c - int'(Lat) - 2) % 4);
                check("rr_resp_valid", resp_valid, oh);
                check("rr_resp_out", resp_out, rr_exp[(c - int'(Lat) - 2) % 4]);
            end else begin
                check("rr_resp_idle", resp_valid, 4'b0000);
            end
        end

        // DIV hazard: requester 0 DIV, requester 1 MULT waiting behind it.
        set_instr(0, {3'd3, 2'b00, 32'h4080_0000, 32'h4000_0000});
        set_instr(1, {3'd2, 2'b00, 32'h0000_00FF, 32'h0000_0F00});
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0011 : ((c <= 6) ? 4'b0010 : 4'b0000);
            #1;
            if (c == 0) check("div_grant", req_ready, 4'b0001);
            if (c >= 1 && c <= 5) begin
                check("div_hold_ready", req_ready, 4'b0000);
                check("div_hold_busy", busy, 1'b1);
            end
            if (c == 6) check("div_mult_grant", req_ready, 4'b0010);
            check("div_start", fpu_start, (c == 1 || c == 7));
            if (c == 6) begin
                check("div_resp_valid", resp_valid, 4'b0001);
                check("div_resp_out", resp_out, 32'h0080_0000);
            end else if (c == 12) begin
                check("mult_resp_valid", resp_valid, 4'b0010);
                check("mult_resp_out", resp_out, 32'h0000_0FFF);
            end else begin
                check("div_resp_idle", resp_valid, 4'b0000);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        check("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
- Shares one fixed-latency FPU core between NUM_REQ requesters.
- Each requester presents an fpu_instruction_t: fpu_op (3 b), rmode (2 b), opa (32 b), opb (32 b), 69 b packed in that order, MSB first.
- Arbitration is round-robin, and the block enforces a DIV issue-interval hazard.
- Each FPU result and its flags are routed back to the requester that issued the instruction, tracked by a tag pipeline.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- FPU_LAT, 4: cycles from fpu_start to valid fpu_out/fpu_flags (>=1).
- DIV_II, 6: minimum cycles between a DIV issue and the next issue of any op (>=1; 1 = no hold).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester instruction valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_instr  in  NUM_REQ*69  packed fpu_instruction_t per requester; requester i is at bits [i*69 +: 69].
- fpu_i  out  69  instruction to the FPU core.
- fpu_start  out  1  one-cycle pulse qualifying fpu_i.
- fpu_out  in  32  FPU result (float_t).
- fpu_flags  in  8  {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}, bit7..bit0.
- resp_valid  out  NUM_REQ  one-hot result strobe.
- resp_out  out  32  result.
- resp_flags  out  8  flags, same order as fpu_flags.
- busy  out  1  high when any instruction is in flight or the FSM is in DIV_HOLD.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0; rr_ptr=0; FSM=READY; hold counter=0; tag pipeline cleared.
  - Instructions in flight at reset are dropped; no resp_valid is ever produced for them.
- FSM:
  - READY: issue is allowed.
  - DIV_HOLD: issue is blocked; all req_ready=0.
  - READY -> DIV_HOLD on acceptance of a DIV when DIV_II>1; hold counter loads DIV_II-1.
  - In DIV_HOLD the counter decrements each cycle; DIV_HOLD -> READY in the cycle the counter is 1.
  - Net effect: the next acceptance happens DIV_II cycles after the DIV acceptance.
- Arbitration (combinational, only in READY):
  - The grant goes to the first requester with req_valid=1, searching from index rr_ptr upward modulo NUM_REQ.
  - req_ready = one-hot grant; all zero if no requester is valid.
  - A transfer occurs when req_valid[i] & req_ready[i]. On transfer, rr_ptr <= (i+1) mod NUM_REQ; otherwise rr_ptr holds.
  - req_ready does not depend on downstream state, because responses cannot be back-pressured.
- Issue: a transfer in cycle t produces registered fpu_i and fpu_start=1 in cycle t+1.
  - fpu_start is 0 in all other cycles.
  - fpu_i holds its last value when idle.
- Illegal opcode (fpu_op 4..7):
  - Still accepted and tagged; fpu_start stays 0.
  - Response is forced to resp_out=32'h7FC00000, resp_flags=8'b0010_0000 (qnan).
  - Illegal opcodes never enter DIV_HOLD.
- Tag pipeline:
  - FPU_LAT+1 stages, each holding {valid, requester index, illegal}.
  - A stage loads at the fpu_start cycle, or at the equivalent cycle for an illegal op.
  - fpu_out/fpu_flags are sampled in cycle t+1+FPU_LAT.
  - resp_valid[idx], resp_out and resp_flags are registered and visible in cycle t+2+FPU_LAT. Total latency from transfer to response = FPU_LAT+2 cycles.
  - resp_valid is a one-cycle pulse; resp_out/resp_flags are 0 when no response is valid.
- Throughput: one non-DIV issue per cycle; responses return in issue order with no gaps added.
- busy = any tag stage valid OR FSM==DIV_HOLD OR resp_valid!=0.
- A requester that drops req_valid without a transfer is legal; no state changes.
- req_instr is sampled only in the transfer cycle.

Test Plan:
- Single ADD: requester 2 issues ADD opa=32'h3F800000, opb=32'h40000000; FPU model returns 32'h40400000 -> fpu_start one cycle after the transfer; resp_valid=4'b0100 with 32'h40400000 exactly FPU_LAT+2 cycles after the transfer.
- Round-robin fairness: all 4 requesters hold req_valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses arrive in the same order on consecutive cycles.
- DIV hazard, DIV_II=6: requester 0 issues DIV at cycle 10 while requester 1 holds a MULT -> req_ready=0 in cycles 11-15; MULT accepted in cycle 16; busy=1 throughout.
- Illegal opcode 3'b110 from requester 3 -> fpu_start stays 0; resp_valid[3] with 32'h7FC00000 and flags 8'h20 at FPU_LAT+2 cycles.
- Reset mid-flight: 3 ADDs in flight, pulse reset asynchronously (not clock-aligned) -> all outputs 0 immediately; no resp_valid after reset release; next grant goes to requester 0.
- Divide-by-zero flag passthrough: FPU model returns flags 8'h81 for a DIV -> resp_flags=8'h81 on the issuing requester's strobe.
